omsp_sram_ctrl: RTL and testbench

//  Parametrised external async-SRAM controller for openMSP430 SOPC; successor to single-cycle SRAM bridge.

---
 rtl/omsp_sram_ctrl_pkg.sv | 21 ++
 rtl/omsp_sram_ctrl_if.sv | 32 +++
 rtl/omsp_sram_wait_cnt.sv | 46 ++++
 rtl/omsp_sram_ctrl.sv | 177 +++++++++++++++++
 tb/tb_omsp_sram_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/omsp_sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// omsp_sram_ctrl_pkg
//   Shared definitions for the external async-SRAM controller:
//   FSM state encoding, wait-counter width and SRAM data-bus width.
// -----------------------------------------------------------------------------
package omsp_sram_ctrl_pkg;

   // Wait-state counter width; RD_WAIT / WR_WAIT must fit (0..15).
   localparam int WAIT_CW = 4;

   // SRAM data bus width.
   localparam int DQ_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_HOLD = 2'd3
   } sram_state_e;

endpackage

// File: rtl/omsp_sram_ctrl_if.sv
// -----------------------------------------------------------------------------
// omsp_sram_ctrl_if
//   Core-side memory port of the SRAM controller.
//   master : core/peripheral issuing requests
//   slave  : omsp_sram_ctrl
//   Signals:
//     ram_addr  word address            ram_cen  active-low request
//     ram_wen   active-low byte enables (2'b11 = read)
//     ram_din   write data              ram_dout read data (held until next read)
//     ram_ack   one-cycle completion    ram_busy controller not idle
// -----------------------------------------------------------------------------
interface omsp_sram_ctrl_if #(
   parameter int ADDR_WIDTH = 9
);
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_cen;
   logic [1:0]            ram_wen;
   logic [15:0]           ram_din;
   logic [15:0]           ram_dout;
   logic                  ram_ack;
   logic                  ram_busy;

   modport master (
      output ram_addr, ram_cen, ram_wen, ram_din,
      input  ram_dout, ram_ack, ram_busy
   );

   modport slave (
      input  ram_addr, ram_cen, ram_wen, ram_din,
      output ram_dout, ram_ack, ram_busy
   );
endinterface

// File: rtl/omsp_sram_wait_cnt.sv
// -----------------------------------------------------------------------------
// omsp_sram_wait_cnt
//   Loadable down-counter with zero flag, used to time both the read strobe
//   and the write strobe of the SRAM controller. Saturates at zero.
//   Ports:
//     clk        in  clock
//     reset_n    in  synchronous active-low reset
//     load_i     in  load load_val_i (has priority over dec_i)
//     load_val_i in  value to load
//     dec_i      in  decrement request (ignored at zero)
//     zero_o     out counter is zero
// -----------------------------------------------------------------------------
module omsp_sram_wait_cnt
   import omsp_sram_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load_i,
   input  logic [WAIT_CW-1:0] load_val_i,
   input  logic               dec_i,
   output logic               zero_o
);

   logic [WAIT_CW-1:0] cnt_q;
   logic [WAIT_CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/omsp_sram_ctrl.sv
// -----------------------------------------------------------------------------
// omsp_sram_ctrl
//   External asynchronous SRAM controller for the openMSP430 SOPC.
//   Accepts one request at a time from the core memory port, drives the
//   SRAM pins with programmable read/write wait states and byte lanes,
//   and signals completion with a one-cycle ram_ack pulse.
//   All SRAM pin outputs are registered.
//
//   Parameters:
//     ADDR_WIDTH  core word-address width (<= SRAM_AW)
//     SRAM_AW     SRAM pin address width (upper bits zero-extended)
//     RD_WAIT     extra read strobe cycles  (0..15)
//     WR_WAIT     extra write strobe cycles (0..15)
//
//   Ports:
//     clk          in   system clock
//     reset_n      in   synchronous active-low reset
//     bus_if       slave modport of omsp_sram_ctrl_if (core side)
//     sram_dq_io   io   SRAM data bus, driven only during write/hold
//     sram_addr_o  out  SRAM address
//     sram_ce_n_o  out  chip enable      sram_oe_n_o  out  output enable
//     sram_we_n_o  out  write enable     sram_ub_n_o  out  upper byte
//     sram_lb_n_o  out  lower byte       (all active low)
//
//   Build option:
//     SRAM_POSTED_WR_EN  write ack is posted on the cycle after accept;
//                        the write still runs to completion with busy high.
// -----------------------------------------------------------------------------
module omsp_sram_ctrl
   import omsp_sram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int SRAM_AW    = 18,
   parameter int RD_WAIT    = 1,
   parameter int WR_WAIT    = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   omsp_sram_ctrl_if.slave    bus_if,
   inout  wire  [DQ_W-1:0]    sram_dq_io,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic               sram_ce_n_o,
   output logic               sram_oe_n_o,
   output logic               sram_we_n_o,
   output logic               sram_ub_n_o,
   output logic               sram_lb_n_o
);

   sram_state_e        state_q;
   logic [SRAM_AW-1:0] addr_q;
   logic               ce_n_q;
   logic               oe_n_q;
   logic               we_n_q;
   logic               ub_n_q;
   logic               lb_n_q;
   logic               dq_oe_q;
   logic [DQ_W-1:0]    dq_out_q;
   logic [DQ_W-1:0]    dout_q;
   logic               ack_q;

   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  accept;
   logic                  is_read;
   logic                  wait_zero;
   logic [WAIT_CW-1:0]    wait_load;

   assign req_addr  = bus_if.ram_addr;
   assign accept    = (state_q == ST_IDLE) && !bus_if.ram_cen;
   assign is_read   = &bus_if.ram_wen;
   assign wait_load = is_read ? WAIT_CW'(RD_WAIT) : WAIT_CW'(WR_WAIT);

   omsp_sram_wait_cnt u_wait_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (accept),
      .load_val_i (wait_load),
      .dec_i      ((state_q == ST_RD) || (state_q == ST_WR)),
      .zero_o     (wait_zero)
   );

   // Main FSM; every pin-level output is a register updated here.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
         dout_q  <= '0;
         ack_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!bus_if.ram_cen) begin
                  addr_q <= SRAM_AW'(req_addr);
                  ce_n_q <= 1'b0;
                  if (is_read) begin
                     state_q <= ST_RD;
                     oe_n_q  <= 1'b0;
                     we_n_q  <= 1'b1;
                     ub_n_q  <= 1'b0;
                     lb_n_q  <= 1'b0;
                     dq_oe_q <= 1'b0;
                  end else begin
                     state_q <= ST_WR;
                     oe_n_q  <= 1'b1;
                     we_n_q  <= 1'b0;
                     ub_n_q  <= bus_if.ram_wen[1];
                     lb_n_q  <= bus_if.ram_wen[0];
                     dq_oe_q <= 1'b1;
`ifdef SRAM_POSTED_WR_EN
                     ack_q   <= 1'b1;
`endif
                  end
               end
            end
            ST_RD: begin
               // Last strobe cycle: capture the bus and release the SRAM.
               if (wait_zero) begin
                  state_q <= ST_IDLE;
                  dout_q  <= sram_dq_io;
                  ack_q   <= 1'b1;
                  ce_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  ub_n_q  <= 1'b1;
                  lb_n_q  <= 1'b1;
               end
            end
            ST_WR: begin
               // WE_N rises first; CE_N and data stay one more cycle for hold.
               if (wait_zero) begin
                  state_q <= ST_HOLD;
                  we_n_q  <= 1'b1;
               end
            end
            ST_HOLD: begin
               state_q <= ST_IDLE;
               ce_n_q  <= 1'b1;
               ub_n_q  <= 1'b1;
               lb_n_q  <= 1'b1;
               dq_oe_q <= 1'b0;
`ifdef SRAM_POSTED_WR_EN
`else
               ack_q   <= 1'b1;
`endif
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Write data register carries no control meaning, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         dq_out_q <= bus_if.ram_din;
      end
   end

   assign sram_dq_io  = dq_oe_q ? dq_out_q : {DQ_W{1'bz}};
   assign sram_addr_o = addr_q;
   assign sram_ce_n_o = ce_n_q;
   assign sram_oe_n_o = oe_n_q;
   assign sram_we_n_o = we_n_q;
   assign sram_ub_n_o = ub_n_q;
   assign sram_lb_n_o = lb_n_q;

   assign bus_if.ram_dout = dout_q;
   assign bus_if.ram_ack  = ack_q;
   assign bus_if.ram_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_omsp_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_omsp_sram_ctrl
//   Scoreboard bench for omsp_sram_ctrl with an async-SRAM device model and
//   a word-array reference model. Build with SRAM_POSTED_WR_EN defined to
//   exercise the posted-write variant.
// -----------------------------------------------------------------------------
module tb_omsp_sram_ctrl;

   localparam int AW  = 9;
   localparam int SAW = 18;
   localparam int RDW = 2;
   localparam int WRW = 1;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   omsp_sram_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   wire  [15:0]    sram_dq;
   logic [SAW-1:0] sram_addr;
   logic           ce_n, oe_n, we_n, ub_n, lb_n;

   omsp_sram_ctrl #(
      .ADDR_WIDTH (AW),
      .SRAM_AW    (SAW),
      .RD_WAIT    (RDW),
      .WR_WAIT    (WRW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus_if      (bus.slave),
      .sram_dq_io  (sram_dq),
      .sram_addr_o (sram_addr),
      .sram_ce_n_o (ce_n),
      .sram_oe_n_o (oe_n),
      .sram_we_n_o (we_n),
      .sram_ub_n_o (ub_n),
      .sram_lb_n_o (lb_n)
   );

   // ---------------- async SRAM device model ----------------
   logic [15:0] dev_mem [0:(1<<AW)-1];
   wire         dev_drive = !ce_n && !oe_n && we_n;
   assign sram_dq = dev_drive ? dev_mem[sram_addr[AW-1:0]] : 16'hzzzz;

   logic          pend = 1'b0;
   logic [AW-1:0] p_addr;
   logic [15:0]   p_dq;
   logic          p_ub, p_lb;

   // Write committed when WE_N rises with CE_N still low; dropped on abort.
   initial forever begin
      @(negedge clk);
      if (!ce_n && !we_n) begin
         pend   = 1'b1;
         p_addr = sram_addr[AW-1:0];
         p_dq   = sram_dq;
         p_ub   = ub_n;
         p_lb   = lb_n;
      end else if (pend) begin
         if (!ce_n) begin
            if (!p_ub) dev_mem[p_addr][15:8] = p_dq[15:8];
            if (!p_lb) dev_mem[p_addr][7:0]  = p_dq[7:0];
         end
         pend = 1'b0;
      end
   end

   // ---------------- reference model and scoreboard ----------------
   logic [15:0] ref_mem [0:(1<<AW)-1];

   typedef struct {
      logic        is_rd;
      logic [15:0] data;
      int unsigned cyc;
   } ack_exp_t;

   typedef struct {
      logic           is_rd;
      logic [SAW-1:0] addr;
      logic [1:0]     wen;
      logic [15:0]    din;
   } strb_exp_t;

   ack_exp_t  ack_sb  [$];
   strb_exp_t strb_sb [$];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Ack monitor: timing, read data, dout retention, busy at completion.
   logic [15:0] exp_dout = 16'h0;
   initial forever begin
      ack_exp_t e;
      @(negedge clk);
      if (!reset_n) exp_dout = 16'h0;
      if (mon_en && bus.ram_ack) begin
         if (ack_sb.size() == 0) begin
            check("ack_unexpected", 32'd1, 32'd0);
         end else begin
            e = ack_sb.pop_front();
            check("ack_cycle", cyc, e.cyc);
            if (e.is_rd) begin
               check("rd_data", {16'h0, bus.ram_dout}, {16'h0, e.data});
               check("busy_rd_ack", {31'h0, bus.ram_busy}, 32'd0);
               exp_dout = e.data;
            end else begin
               check("dout_kept", {16'h0, bus.ram_dout}, {16'h0, exp_dout});
`ifdef SRAM_POSTED_WR_EN
               check("busy_wr_ack", {31'h0, bus.ram_busy}, 32'd1);
`else
               check("busy_wr_ack", {31'h0, bus.ram_busy}, 32'd0);
`endif
            end
         end
      end
   end

   // Strobe monitor: address/lanes/data at strobe start, strobe lengths.
   initial begin
      strb_exp_t s;
      logic ce_prev = 1'b1;
      int   oe_run  = 0;
      int   we_run  = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (!ce_n && ce_prev) begin
               if (strb_sb.size() == 0) begin
                  check("strobe_unexpected", 32'd1, 32'd0);
               end else begin
                  s = strb_sb.pop_front();
                  check("sram_addr", 32'(sram_addr), 32'(s.addr));
                  if (s.is_rd) begin
                     check("rd_strobes", {28'h0, oe_n, we_n, ub_n, lb_n}, 32'b0100);
                  end else begin
                     check("wr_strobes", {28'h0, oe_n, we_n, ub_n, lb_n}, {28'h0, 2'b10, s.wen});
                     check("wr_dq", {16'h0, sram_dq}, {16'h0, s.din});
                  end
               end
            end
            if (!oe_n) oe_run++;
            else if (oe_run > 0) begin
               check("oe_len", 32'(oe_run), 32'(RDW + 1));
               oe_run = 0;
            end
            if (!we_n) we_run++;
            else if (we_run > 0) begin
               check("we_len", 32'(we_run), 32'(WRW + 1));
               we_run = 0;
            end
         end
         ce_prev = ce_n;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle(input bit noise, output bit ok);
      int guard = 0;
      ok = 1'b1;
      while (bus.ram_busy) begin
         if (noise) begin
            bus.ram_cen  = 1'($urandom_range(0, 1));
            bus.ram_addr = AW'($urandom);
            bus.ram_wen  = 2'($urandom);
            bus.ram_din  = 16'($urandom);
         end
         @(negedge clk);
         guard++;
         if (guard > 100) begin
            check("busy_timeout", 32'd1, 32'd0);
            ok = 1'b0;
            break;
         end
      end
      bus.ram_cen = 1'b1;
   endtask

   task automatic issue(input logic [AW-1:0] a, input logic [1:0] w,
                        input logic [15:0] d, input bit noise);
      ack_exp_t  e;
      strb_exp_t s;
      bit        ok;
      wait_idle(noise, ok);
      if (!ok) return;
      e.is_rd = (w == 2'b11);
      if (e.is_rd) begin
         e.data = ref_mem[a];
         e.cyc  = cyc + RDW + 2;
      end else begin
         if (!w[1]) ref_mem[a][15:8] = d[15:8];
         if (!w[0]) ref_mem[a][7:0]  = d[7:0];
         e.data = 16'h0;
`ifdef SRAM_POSTED_WR_EN
         e.cyc  = cyc + 1;
`else
         e.cyc  = cyc + WRW + 3;
`endif
      end
      s.is_rd = e.is_rd;
      s.addr  = SAW'(a);
      s.wen   = w;
      s.din   = d;
      ack_sb.push_back(e);
      strb_sb.push_back(s);
      bus.ram_addr = a;
      bus.ram_wen  = w;
      bus.ram_din  = d;
      bus.ram_cen  = 1'b0;
      @(negedge clk);
      bus.ram_cen  = 1'b1;
   endtask

   initial begin
      int  diff;
      int  guard;
      bit  ok;
      logic [AW-1:0] a;
      logic [1:0]    w;

      bus.ram_cen  = 1'b1;
      bus.ram_addr = '0;
      bus.ram_wen  = 2'b11;
      bus.ram_din  = '0;
      for (int i = 0; i < (1 << AW); i++) begin
         dev_mem[i] = 16'($urandom);
         ref_mem[i] = dev_mem[i];
      end
      dev_mem[9'h1A5] = 16'hBEEF;
      ref_mem[9'h1A5] = 16'hBEEF;
      dev_mem[9'h010] = 16'hA5C3;
      ref_mem[9'h010] = 16'hA5C3;

      // Reset held for three clock edges.
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_strobes", {27'h0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_dout", {16'h0, bus.ram_dout}, 32'd0);
      check("rst_ack", {31'h0, bus.ram_ack}, 32'd0);
      check("rst_busy", {31'h0, bus.ram_busy}, 32'd0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(negedge clk);

      // Directed: read, byte write (upper lane), back-to-back read-back.
      issue(9'h1A5, 2'b11, 16'h0000, 1'b0);
      issue(9'h010, 2'b01, 16'h1234, 1'b0);
      issue(9'h010, 2'b11, 16'h0000, 1'b0);
      issue(9'h011, 2'b10, 16'h5678, 1'b0);
      issue(9'h011, 2'b11, 16'h0000, 1'b0);

      // Directed: reset during the second write strobe cycle aborts the write.
      wait_idle(1'b0, ok);
      begin
         strb_exp_t s;
         s.is_rd = 1'b0;
         s.addr  = SAW'(9'h0AA);
         s.wen   = 2'b00;
         s.din   = 16'hDEAD;
         strb_sb.push_back(s);
`ifdef SRAM_POSTED_WR_EN
         begin
            ack_exp_t e;
            e.is_rd = 1'b0;
            e.data  = 16'h0;
            e.cyc   = cyc + 1;
            ack_sb.push_back(e);
         end
`endif
      end
      bus.ram_addr = 9'h0AA;
      bus.ram_wen  = 2'b00;
      bus.ram_din  = 16'hDEAD;
      bus.ram_cen  = 1'b0;
      @(negedge clk);
      bus.ram_cen  = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("abort_we_n", {31'h0, we_n}, 32'd1);
      check("abort_ce_n", {31'h0, ce_n}, 32'd1);
      check("abort_ack", {31'h0, bus.ram_ack}, 32'd0);
      check("abort_busy", {31'h0, bus.ram_busy}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      issue(9'h0AA, 2'b11, 16'h0000, 1'b0);

      // Randomised traffic with ignored requests injected while busy.
      for (int n = 0; n < 300; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
         w = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 2));
         issue(a, w, 16'($urandom), 1'b1);
      end

      // Drain outstanding work.
      guard = 0;
      while ((ack_sb.size() != 0 || bus.ram_busy) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
      check("drain_ack", 32'(ack_sb.size()), 32'd0);
      check("drain_strobe", 32'(strb_sb.size()), 32'd0);

      diff = 0;
      for (int i = 0; i < (1 << AW); i++) begin
         if (dev_mem[i] !== ref_mem[i]) diff++;
      end
      check("mem_image", 32'(diff), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
